// File: rtl/load_store_ctrl_pkg.sv
// rtl/load_store_ctrl_pkg.sv - opcode/func3 constants and access alignment helper
package load_store_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    // Halfwords only fault when they straddle the word; unknown func3 is treated as a fault.
    function automatic logic access_misaligned(input logic is_store, input logic [2:0] func3,
                                               input logic [1:0] off);
        if (func3 == FNC_LB || (!is_store && func3 == FNC_LBU))
            return 1'b0;
        if (func3 == FNC_LH || (!is_store && func3 == FNC_LHU))
            return (off == 2'b11);
        if (func3 == FNC_LW)
            return (off != 2'b00);
        return 1'b1;
    endfunction

endpackage

// File: rtl/load_store_ctrl_store_align.sv
// rtl/load_store_ctrl_store_align.sv - byte enables, lane-shifted store data and alignment fault
module load_store_ctrl_store_align
    import load_store_ctrl_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  func3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rs2_i,
    output logic [3:0]  we_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o
);

    always_comb begin
        we_o         = 4'b0000;
        wdata_o      = 32'h0;
        misaligned_o = access_misaligned(is_store_i, func3_i, off_i);
        if (is_store_i && !misaligned_o) begin
            case (func3_i)
                FNC_SB: begin
                    we_o    = 4'b0001 << off_i;
                    wdata_o = {4{rs2_i[7:0]}};
                end
                FNC_SH: begin
                    we_o    = 4'b0011 << off_i;
                    wdata_o = {16'h0, rs2_i[15:0]} << {off_i, 3'b000};
                end
                FNC_SW: begin
                    we_o    = 4'b1111;
                    wdata_o = rs2_i;
                end
                default: begin
                    we_o    = 4'b0000;
                    wdata_o = 32'h0;
                end
            endcase
        end
    end

endmodule

// File: rtl/load_store_ctrl.sv
// rtl/load_store_ctrl.sv - memory-stage load/store request controller
module load_store_ctrl
    import load_store_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_rs2,
    output logic        ex_ready,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_we,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        wb_valid,
    output logic [31:0] wb_inst,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_data_raw,
    output logic        misaligned,
    output logic        bus_error
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_valid_q, req_valid_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [3:0]         req_we_q, req_we_d;
    logic [31:0]        req_wdata_q, req_wdata_d;
    logic               wb_valid_q, wb_valid_d;
    logic [31:0]        wb_inst_q, wb_inst_d;
    logic [31:0]        wb_addr_q, wb_addr_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               mis_q, mis_d;
    logic               berr_q, berr_d;

    logic               ex_is_load, ex_is_store, accept, cur_is_store, timeout_hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic [3:0]         sa_we;
    logic [31:0]        sa_wdata;
    logic               sa_mis;

    assign ex_is_load   = (ex_inst[6:0] == OPC_LOAD);
    assign ex_is_store  = (ex_inst[6:0] == OPC_STORE);
    assign ex_ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept       = ex_valid && ex_ready;
    assign cur_is_store = (wb_inst_q[6:0] == OPC_STORE);
    assign cnt_inc      = cnt_q + 1'b1;
    assign timeout_hit  = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    load_store_ctrl_store_align u_store_align (
        .is_store_i   (ex_is_store),
        .func3_i      (ex_inst[14:12]),
        .off_i        (ex_addr[1:0]),
        .rs2_i        (ex_rs2),
        .we_o         (sa_we),
        .wdata_o      (sa_wdata),
        .misaligned_o (sa_mis)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_we_d    = req_we_q;
        req_wdata_d = req_wdata_q;
        wb_valid_d  = 1'b0;
        wb_inst_d   = wb_inst_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        mis_d       = 1'b0;
        berr_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    wb_inst_d = ex_inst;
                    wb_addr_d = ex_addr;
                    wb_data_d = 32'h0;
                    if (!(ex_is_load || ex_is_store)) begin
                        wb_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (sa_mis) begin
                        wb_valid_d = 1'b1;
                        mis_d      = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        req_valid_d = 1'b1;
                        req_addr_d  = {ex_addr[31:2], 2'b00};
                        req_we_d    = sa_we;
                        req_wdata_d = sa_wdata;
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // A handshake in the final cycle wins over the timeout: memory already owns it.
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (cur_is_store) begin
                        wb_valid_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        state_d    = ST_WAIT;
                    end
                end else if (timeout_hit) begin
                    req_valid_d = 1'b0;
                    wb_valid_d  = 1'b1;
                    berr_d      = 1'b1;
                    wb_data_d   = 32'h0;
                    state_d     = ST_DONE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_resp_valid) begin
                    wb_data_d  = mem_resp_data;
                    wb_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (timeout_hit) begin
                    wb_valid_d = 1'b1;
                    berr_d     = 1'b1;
                    wb_data_d  = 32'h0;
                    state_d    = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            req_addr_q  <= 32'h0;
            req_we_q    <= 4'h0;
            req_wdata_q <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_inst_q   <= 32'h0;
            wb_addr_q   <= 32'h0;
            wb_data_q   <= 32'h0;
            mis_q       <= 1'b0;
            berr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_inst_q   <= wb_inst_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            mis_q       <= mis_d;
            berr_q      <= berr_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_we    = req_we_q;
    assign mem_req_wdata = req_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_inst       = wb_inst_q;
    assign wb_addr       = wb_addr_q;
    assign wb_data_raw   = wb_data_q;
    assign misaligned    = mis_q;
    assign bus_error     = berr_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb/tb_load_store_ctrl.sv - scoreboard testbench for load_store_ctrl
module tb_load_store_ctrl;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_OP    = 7'b0110011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
        logic        berr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_inst = 32'h0;
    logic [31:0] ex_addr = 32'h0;
    logic [31:0] ex_rs2 = 32'h0;
    logic        ex_ready;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_we;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        wb_valid;
    logic [31:0] wb_inst;
    logic [31:0] wb_addr;
    logic [31:0] wb_data_raw;
    logic        misaligned;
    logic        bus_error;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    load_store_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_inst        (ex_inst),
        .ex_addr        (ex_addr),
        .ex_rs2         (ex_rs2),
        .ex_ready       (ex_ready),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_we     (mem_req_we),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .wb_valid       (wb_valid),
        .wb_inst        (wb_inst),
        .wb_addr        (wb_addr),
        .wb_data_raw    (wb_data_raw),
        .misaligned     (misaligned),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got inst=%h addr=%h data=%h", wb_inst, wb_addr, wb_data_raw);
            end else begin
                mon_e = sb_q.pop_front();
                if ({wb_inst, wb_addr, wb_data_raw, misaligned, bus_error} !== mon_e) begin
                    errors++;
                    $display("FAIL wb_fields got inst=%h addr=%h data=%h mis=%b berr=%b exp inst=%h addr=%h data=%h mis=%b berr=%b",
                             wb_inst, wb_addr, wb_data_raw, misaligned, bus_error,
                             mon_e.inst, mon_e.addr, mon_e.data, mon_e.mis, mon_e.berr);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
        return {12'h5A3, 5'd7, f3, 5'd9, opc};
    endfunction

    task automatic push_exp(input logic [31:0] inst, addr, data, input logic mis, berr);
        exp_t e;
        e = '{inst: inst, addr: addr, data: data, mis: mis, berr: berr};
        sb_q.push_back(e);
    endtask

    task automatic drive_accept(input logic [31:0] inst, addr, rs2);
        @(negedge clk);
        ex_valid = 1'b1; ex_inst = inst; ex_addr = addr; ex_rs2 = rs2;
        @(posedge clk);
        #1 ex_valid = 1'b0;
    endtask

    // Accepts one instruction and plays memory: ready after `stall` request cycles, response one cycle after handshake.
    task automatic run_txn(input logic [31:0] inst, addr, rs2, input int stall, input bit respond,
                           input logic [31:0] rdata, output int lat, output int reqc,
                           output logic [31:0] r_addr, output logic [3:0] r_we, output logic [31:0] r_wdata,
                           output int unstable, output int busy_rdy);
        bit hs;
        hs = 0; lat = -1; reqc = 0; unstable = 0; busy_rdy = 0;
        r_addr = 32'h0; r_we = 4'h0; r_wdata = 32'h0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        drive_accept(inst, addr, rs2);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (wb_valid) begin
                lat = c;
                break;
            end
            if (ex_ready) busy_rdy++;
            if (hs && respond) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = rdata;
            end
            hs = 0;
            if (mem_req_valid) begin
                reqc++;
                if (reqc == 1) begin
                    r_addr = mem_req_addr; r_we = mem_req_we; r_wdata = mem_req_wdata;
                end else if ({mem_req_addr, mem_req_we, mem_req_wdata} !== {r_addr, r_we, r_wdata}) begin
                    unstable++;
                end
                mem_req_ready = (reqc > stall);
                hs = mem_req_ready;
            end else begin
                mem_req_ready = 1'b0;
            end
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, wb_valid, wb_inst, wb_addr,
             wb_data_raw, misaligned, bus_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got req_valid=%b wb_valid=%b wb_inst=%h exp all zero", mem_req_valid, wb_valid, wb_inst);
        end
        checks++;
        if (ex_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ex_ready got=%b exp=1", ex_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_load();
        int lat, reqc, unst, brdy;
        logic [31:0] ra, rw;
        logic [3:0]  rwe;
        logic [31:0] insts [2];
        logic [31:0] addrs [2];
        logic [31:0] datas [2];
        insts[0] = mk(3'b010, T_LOAD); addrs[0] = 32'h0000_1000; datas[0] = 32'hDEAD_BEEF;
        insts[1] = mk(3'b100, T_LOAD); addrs[1] = 32'h0000_1003; datas[1] = 32'h1122_3344;
        for (int i = 0; i < 2; i++) begin
            push_exp(insts[i], addrs[i], datas[i], 1'b0, 1'b0);
            run_txn(insts[i], addrs[i], 32'hFFFF_FFFF, 0, 1'b1, datas[i], lat, reqc, ra, rwe, rw, unst, brdy);
            checks++;
            if (lat !== 3) begin errors++; $display("FAIL load_latency[%0d] got=%0d exp=3", i, lat); end
            checks++;
            if (ra !== {addrs[i][31:2], 2'b00}) begin errors++; $display("FAIL load_req_addr[%0d] got=%h exp=%h", i, ra, {addrs[i][31:2], 2'b00}); end
            checks++;
            if (rwe !== 4'b0000) begin errors++; $display("FAIL load_we[%0d] got=%b exp=0000", i, rwe); end
            checks++;
            if (reqc !== 1) begin errors++; $display("FAIL load_req_cycles[%0d] got=%0d exp=1", i, reqc); end
        end
    endtask

    task automatic test_store();
        int lat, reqc, unst, brdy;
        logic [31:0] ra, rw;
        logic [3:0]  rwe;
        logic [2:0]  f3  [3];
        logic [31:0] ad  [3];
        logic [31:0] rs  [3];
        logic [3:0]  ewe [3];
        logic [31:0] ewd [3];
        f3[0] = 3'b000; ad[0] = 32'h2003; rs[0] = 32'h0000_00A5; ewe[0] = 4'b1000; ewd[0] = 32'hA5A5_A5A5;
        f3[1] = 3'b001; ad[1] = 32'h2001; rs[1] = 32'hFFFF_1234; ewe[1] = 4'b0110; ewd[1] = 32'h0012_3400;
        f3[2] = 3'b010; ad[2] = 32'h2004; rs[2] = 32'hCAFE_F00D; ewe[2] = 4'b1111; ewd[2] = 32'hCAFE_F00D;
        for (int i = 0; i < 3; i++) begin
            push_exp(mk(f3[i], T_STORE), ad[i], 32'h0, 1'b0, 1'b0);
            run_txn(mk(f3[i], T_STORE), ad[i], rs[i], 0, 1'b0, 32'h0, lat, reqc, ra, rwe, rw, unst, brdy);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL store_latency[%0d] got=%0d exp=2", i, lat); end
            checks++;
            if (rwe !== ewe[i]) begin errors++; $display("FAIL store_we[%0d] got=%b exp=%b", i, rwe, ewe[i]); end
            checks++;
            if (rw !== ewd[i]) begin errors++; $display("FAIL store_wdata[%0d] got=%h exp=%h", i, rw, ewd[i]); end
            checks++;
            if (ra !== {ad[i][31:2], 2'b00}) begin errors++; $display("FAIL store_addr[%0d] got=%h exp=%h", i, ra, {ad[i][31:2], 2'b00}); end
        end
    endtask

    task automatic test_misaligned();
        int lat, reqc, unst, brdy;
        logic [31:0] ra, rw;
        logic [3:0]  rwe;
        logic [31:0] ins [3];
        logic [31:0] ad  [3];
        ins[0] = mk(3'b001, T_LOAD);  ad[0] = 32'h3003;
        ins[1] = mk(3'b010, T_STORE); ad[1] = 32'h3002;
        ins[2] = mk(3'b011, T_STORE); ad[2] = 32'h3000;
        for (int i = 0; i < 3; i++) begin
            push_exp(ins[i], ad[i], 32'h0, 1'b1, 1'b0);
            run_txn(ins[i], ad[i], 32'h5555_5555, 0, 1'b0, 32'h0, lat, reqc, ra, rwe, rw, unst, brdy);
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL mis_latency[%0d] got=%0d exp=1", i, lat); end
            checks++;
            if (reqc !== 0) begin errors++; $display("FAIL mis_no_req[%0d] got=%0d exp=0", i, reqc); end
        end
    endtask

    task automatic test_stall();
        int lat, reqc, unst, brdy;
        logic [31:0] ra, rw;
        logic [3:0]  rwe;
        push_exp(mk(3'b010, T_LOAD), 32'h5008, 32'h7654_3210, 1'b0, 1'b0);
        run_txn(mk(3'b010, T_LOAD), 32'h5008, 32'h0, 4, 1'b1, 32'h7654_3210, lat, reqc, ra, rwe, rw, unst, brdy);
        checks++;
        if (lat !== 7) begin errors++; $display("FAIL stall_latency got=%0d exp=7", lat); end
        checks++;
        if (reqc !== 5) begin errors++; $display("FAIL stall_req_cycles got=%0d exp=5", reqc); end
        checks++;
        if (unst !== 0) begin errors++; $display("FAIL stall_stable got=%0d changes exp=0", unst); end
        checks++;
        if (brdy !== 0) begin errors++; $display("FAIL stall_ex_ready got=%0d high cycles exp=0", brdy); end
    endtask

    task automatic test_timeout();
        int lat, reqc, unst, brdy;
        logic [31:0] ra, rw;
        logic [3:0]  rwe;
        push_exp(mk(3'b010, T_LOAD), 32'h6000, 32'h0, 1'b0, 1'b1);
        run_txn(mk(3'b010, T_LOAD), 32'h6000, 32'h0, 0, 1'b0, 32'h0, lat, reqc, ra, rwe, rw, unst, brdy);
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL timeout_latency got=%0d exp=9", lat); end
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL stray_resp[%0d] got wb_valid=%b exp=0", i, wb_valid); end
        end
        mem_resp_valid = 1'b0;
        push_exp(mk(3'b010, T_LOAD), 32'h6004, 32'h0BAD_F00D, 1'b0, 1'b0);
        run_txn(mk(3'b010, T_LOAD), 32'h6004, 32'h0, 0, 1'b1, 32'h0BAD_F00D, lat, reqc, ra, rwe, rw, unst, brdy);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL post_timeout_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        ex_valid = 1'b1; ex_inst = mk(3'b000, T_OP); ex_addr = 32'h100; ex_rs2 = 32'h0;
        push_exp(ex_inst, ex_addr, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b1 || ex_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_pulse[%0d] got wb_valid=%b ex_ready=%b exp 1 1", i, wb_valid, ex_ready);
            end
            if (i < 3) begin
                ex_inst = mk(3'b000, T_OP) ^ (32'h1 << (20 + i));
                ex_addr = 32'h100 + 32'(i);
                push_exp(ex_inst, ex_addr, 32'h0, 1'b0, 1'b0);
            end else begin
                ex_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_load();
        mem_req_ready = 1'b1;
        drive_accept(mk(3'b010, T_LOAD), 32'h4000, 32'h0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, wb_valid, wb_inst, wb_addr,
             wb_data_raw, misaligned, bus_error} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got req_addr=%h wb_valid=%b wb_inst=%h exp all zero", mem_req_addr, wb_valid, wb_inst);
        end
        checks++;
        if (ex_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_idle got ex_ready=%b exp=1", ex_ready); end
        rst = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_wb[%0d] got=%b exp=0", i, wb_valid); end
        end
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_stall();
        test_timeout();
        test_back_to_back();
        test_reset_mid_load();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
